// File: rtl/serial_add_seq_pkg.sv
// Shared definitions for the nibble-serial add/subtract unit:
// FSM state encoding, slice width and index-width helper.
package serial_add_seq_pkg;

    // Width of one arithmetic slice handled per RUN cycle
    localparam int SLICE_W = 4;

    // Control FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Slice index width: ceil(log2(n)), never below one bit
    function automatic int idx_width(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/ripple_carry_adder_4bit.sv
// Four-bit ripple-carry adder: the single shared slice datapath of the unit.
import serial_add_seq_pkg::*;

module ripple_carry_adder_4bit (
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout
);

    logic [SLICE_W:0]   carry_s;
    logic [SLICE_W-1:0] sum_s;

    // Full-adder chain, carry rippling from bit 0 upwards
    always_comb begin
        carry_s    = {(SLICE_W+1){1'b0}};
        sum_s      = {SLICE_W{1'b0}};
        carry_s[0] = cin;
        for (int i = 0; i < SLICE_W; i++) begin
            sum_s[i]       = a[i] ^ b[i] ^ carry_s[i];
            carry_s[i + 1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
        end
    end

    assign sum  = sum_s;
    assign cout = carry_s[SLICE_W];

endmodule

// File: rtl/serial_add_seq.sv
// Nibble-serial add/subtract unit. One request is latched in IDLE, processed
// one 4-bit slice per RUN cycle through a shared ripple-carry adder, then held
// in DONE until the consumer takes it with a valid/ready handshake.
import serial_add_seq_pkg::*;

module serial_add_seq #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   op_sub,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   cout,
    output logic                   ovf
);

    localparam int W     = SLICE_W * NIBBLES;
    localparam int IDX_W = idx_width(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t             state_r;
    state_t             next_state_s;

    logic [W-1:0]       a_r;
    logic [W-1:0]       bx_r;          // effective B (inverted for subtract)
    logic               carry_r;
    logic [IDX_W-1:0]   idx_r;

    logic [W-1:0]       sum_r;
    logic               cout_r;
    logic               ovf_r;
    logic               out_valid_r;
    logic               in_ready_r;

    logic               accept_s;
    logic               run_s;
    logic               last_slice_s;
    logic               out_hs_s;
    logic [W-1:0]       a_shift_s;
    logic [W-1:0]       b_shift_s;
    logic [SLICE_W-1:0] a_slice_s;
    logic [SLICE_W-1:0] b_slice_s;
    logic [SLICE_W-1:0] add_sum_s;
    logic               add_cout_s;

    assign accept_s     = in_valid && in_ready_r;
    assign run_s        = (state_r == ST_RUN);
    assign last_slice_s = (idx_r == LAST_IDX);
    assign out_hs_s     = out_valid_r && out_ready;

    // Select the current slice of both latched operands
    always_comb begin
        a_shift_s = a_r  >> (SLICE_W * int'(idx_r));
        b_shift_s = bx_r >> (SLICE_W * int'(idx_r));
        a_slice_s = a_shift_s[SLICE_W-1:0];
        b_slice_s = b_shift_s[SLICE_W-1:0];
    end

    ripple_carry_adder_4bit u_rca (
        .a    (a_slice_s),
        .b    (b_slice_s),
        .cin  (carry_r),
        .sum  (add_sum_s),
        .cout (add_cout_s)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    next_state_s = ST_RUN;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_slice_s) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (out_hs_s) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_DONE;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Operand latch, carry and slice-index bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r     <= {W{1'b0}};
            bx_r    <= {W{1'b0}};
            carry_r <= 1'b0;
            idx_r   <= {IDX_W{1'b0}};
        end else if (accept_s) begin
            a_r     <= a;
            bx_r    <= op_sub ? ~b : b;
            carry_r <= op_sub;
            idx_r   <= {IDX_W{1'b0}};
        end else if (run_s) begin
            carry_r <= add_cout_s;
            // Index holds on the last slice so it never runs past NIBBLES-1
            if (!last_slice_s) begin
                idx_r <= idx_r + IDX_W'(1);
            end
        end
    end

    // Result registers: one slice written per RUN cycle, flags on the top slice
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_r  <= {W{1'b0}};
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else if (run_s) begin
            for (int i = 0; i < NIBBLES; i++) begin
                if (idx_r == IDX_W'(i)) begin
                    sum_r[i*SLICE_W +: SLICE_W] <= add_sum_s;
                end
            end
            if (last_slice_s) begin
                cout_r <= add_cout_s;
                ovf_r  <= (a_r[W-1] == bx_r[W-1]) &&
                          (add_sum_s[SLICE_W-1] != a_r[W-1]);
            end
        end
    end

    // out_valid rises one cycle after entering DONE and drops on handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
        end else if ((state_r == ST_DONE) && !out_hs_s) begin
            out_valid_r <= 1'b1;
        end else begin
            out_valid_r <= 1'b0;
        end
    end

    // in_ready is a registered copy of "next state is IDLE"
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready_r <= 1'b1;
        end else begin
            in_ready_r <= (next_state_s == ST_IDLE);
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign sum       = sum_r;
    assign cout      = cout_r;
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_serial_add_seq.sv
// Self-checking bench for serial_add_seq (NIBBLES = 4, 16-bit operands).
module tb_serial_add_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        op_sub;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    int total = 0;
    int bad   = 0;

    serial_add_seq #(.NIBBLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_sub    (op_sub),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] va;
        logic [15:0] vb;
        logic        vop;
        logic [15:0] es;
        logic        ec;
        logic        ev;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic on the operands
    task automatic model(input logic [15:0] ta, input logic [15:0] tb_v, input logic top,
                         output logic [15:0] es, output logic ec, output logic ev);
        int ua, ub, sa, sb, r;
        ua = int'(ta);
        ub = int'(tb_v);
        sa = int'($signed(ta));
        sb = int'($signed(tb_v));
        if (top) begin
            es = 16'(ua - ub);
            ec = (ua >= ub);
            r  = sa - sb;
        end else begin
            es = 16'(ua + ub);
            ec = (ua + ub) > 65535;
            r  = sa + sb;
        end
        ev = (r > 32767) || (r < -32768);
    endtask

    // One full transaction; hold = back-pressure cycles, poke = in_valid during hold
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic top,
                          input logic [15:0] es, input logic ec, input logic ev,
                          input int hold, input bit poke, input string tag);
        int lat;
        bit seen;
        check({tag, "_in_ready_idle"}, in_ready, 1);
        a = ta; b = tb_v; op_sub = top; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); op_sub = 1'($urandom_range(0, 1));
        check({tag, "_in_ready_busy"}, in_ready, 0);
        lat = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            out_ready = 1'($urandom_range(0, 1));
            tick();
            lat++;
            seen = out_valid;
        end
        out_ready = 1'b0;
        check({tag, "_latency"}, seen ? lat : -1, 5);
        check({tag, "_sum"}, sum, es);
        check({tag, "_cout"}, cout, ec);
        check({tag, "_ovf"}, ovf, ev);
        for (int h = 0; h < hold; h++) begin
            if (poke) begin
                in_valid = 1'b1;
                a = 16'hAAAA; b = 16'h1111; op_sub = 1'b0;
            end
            tick();
            check({tag, "_hold_valid"}, out_valid, 1);
            check({tag, "_hold_sum"}, sum, es);
            check({tag, "_hold_in_ready"}, in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_post_hs_valid"}, out_valid, 0);
        check({tag, "_post_hs_in_ready"}, in_ready, 1);
    endtask

    initial begin
        logic [15:0] es;
        logic        ec, ev;
        logic [15:0] ra, rb;
        logic        rop;
        bit          spurious;

        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[4] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};

        rst = 1'b0; in_valid = 1'b0; op_sub = 1'b0; a = 16'h0; b = 16'h0; out_ready = 1'b0;
        #1 rst = 1'b1;
        #2;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_ovf", ovf, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Directed table
        for (int i = 0; i < 5; i++) begin
            run_op(vecs[i].va, vecs[i].vb, vecs[i].vop, vecs[i].es, vecs[i].ec, vecs[i].ev,
                   0, 1'b0, $sformatf("vec%0d", i));
        end

        // Back-pressure with an ignored second request
        model(16'h1111, 16'h2222, 1'b0, es, ec, ev);
        run_op(16'h1111, 16'h2222, 1'b0, es, ec, ev, 3, 1'b1, "bp");
        spurious = 1'b0;
        for (int k = 0; k < 7; k++) begin
            tick();
            if (out_valid || !in_ready) spurious = 1'b1;
        end
        check("bp_no_queue", spurious, 0);

        // Reset during the second RUN cycle
        a = 16'h0F0F; b = 16'h0101; op_sub = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_sum", sum, 0);
        check("mid_rst_cout", cout, 0);
        check("mid_rst_ovf", ovf, 0);
        tick();
        rst = 1'b0;
        spurious = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (out_valid) spurious = 1'b1;
        end
        check("mid_rst_no_valid", spurious, 0);
        run_op(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 0, 1'b0, "after_rst");

        // Randomized transactions against the arithmetic model
        for (int n = 0; n < 25; n++) begin
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            rop = 1'($urandom_range(0, 1));
            if (n == 0) rb = 16'h8000;
            model(ra, rb, rop, es, ec, ev);
            run_op(ra, rb, rop, es, ec, ev, $urandom_range(0, 2), 1'b0, $sformatf("rnd%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
